net_bus_tx_fanout: RTL
======================

Name: net_bus_tx_fanout

Overview:
- Parametrised NetBus transmit fan-out that replaces the fixed six-way broadcast splitter.
- Registers one NetBus word and presents it to PORTS downstream links.
- Tracks per-port delivery, so a word is retired only after every selected port has taken it. The old splitter released a word as soon as any one port was ready; this block does not.
- Supports broadcast-with-mask mode and routed (unicast by destination index) mode. Sits between a NetBus source and the per-link NetBus receive/FIFO blocks.

Parameters:
- DATA_WIDTH, 4, NetBus lane parameter. Word width W = DATA_WIDTH*9+14 (default 50).
- PORTS, 6, number of output links, 2..16.
- MODE, 0, 0 = broadcast to ports set in PORT_EN; 1 = routed to the single port DEST.
- DEST_W, 4, width of DEST; must satisfy 2**DEST_W >= PORTS.

Ports:
- CLK  in  1  single clock for the block and all links.
- RST  in  1  asynchronous, active-high reset.
- DATA  in  W  NetBus word.
- VALID  in  1  source word valid.
- READY  out  1  block accepts the word on CLK rising edge when VALID&READY.
- PORT_EN  in  PORTS  broadcast port mask, sampled with the word (MODE=0 only).
- DEST  in  DEST_W  destination port index, sampled with the word (MODE=1 only).
- WCLK  out  PORTS  per-link clock; every bit equals CLK.
- WDATA  out  PORTS*W  per-link word; slice i = bits [i*W +: W].
- WVALID  out  PORTS  per-link valid.
- WREADY  in  PORTS  per-link ready.
- DROP  out  1  one-cycle pulse: an accepted word had an empty target set.
- BUSY  out  1  buffer holds an undelivered word.

Behaviour:
- State: word register WREG[W], pending mask PEND[PORTS]. BUSY = |PEND.
- Target mask at acceptance:
  - MODE=0: TGT = PORT_EN.
  - MODE=1: TGT = one-hot(DEST) if DEST < PORTS, else 0.
- Outputs:
  - WVALID[i] = PEND[i].
  - WDATA slice i = WREG for all i; shared, valid only where WVALID is set.
  - WCLK[i] = CLK.
- Delivery: on an edge with WVALID[i]&WREADY[i], PEND[i] clears. Other pending bits are unaffected; ports complete independently and in any order.
- LAST = (PEND & ~(WVALID & WREADY)) == 0, i.e. all remaining pending bits clear this cycle.
- READY = ~BUSY | LAST. This is combinational from WREADY; one word per cycle is sustained when all targets are ready.
- Accept (VALID&READY):
  - WREG <= DATA.
  - PEND <= TGT. This overrides the clears of the retiring word; there is no gap cycle.
- Latency: a word accepted at edge n shows WVALID from after edge n until its own handshake. Minimum 1 cycle.
- Empty target (TGT == 0):
  - Word is accepted and discarded; PEND stays 0.
  - DROP = 1 for the cycle after the accepting edge; otherwise DROP = 0.
  - WREG is still loaded.
- A held word never changes. DATA/PORT_EN/DEST are ignored while READY = 0, and VALID may be held without effect.
- No combinational path from VALID to any WVALID.
- Reset (asynchronous, any time including mid-delivery):
  - PEND = 0, WREG = 0, DROP = 0, so WVALID = 0, BUSY = 0, READY = 1.
  - A partially delivered word is lost with no DROP pulse.
  - First accept is possible on the first edge after RST deasserts.
- Simultaneous accept of a new word and final delivery of the old word in the same edge: the old word completes and the new word loads.
- PEND bits not in TGT never assert; ports outside PORTS do not exist.

Test Plan:
- MODE=0, PORT_EN=6'h3F, all WREADY=1, 4 back-to-back words 0x1,0x2,0x3,0x4 -> READY stays 1; each word appears on all 6 WVALID for exactly 1 cycle; 4 words in 5 cycles.
- MODE=0, PORT_EN=6'h3F, WREADY=6'h01 then 6'h3E two cycles later -> port0 takes the word first; READY=0 until the cycle port1..5 handshake; word retired once per port, never duplicated.
- MODE=0, PORT_EN=6'h0A, WREADY all 1 -> only WVALID[1] and WVALID[3] pulse; DROP=0. Then PORT_EN=0 -> no WVALID, DROP=1 for one cycle.
- MODE=1, DEST=4 then DEST=7 (PORTS=6) -> WVALID=6'h10 for the first word; second word dropped with DROP=1; READY never stalls.
- Hold WREADY=0 with word 0xABC pending on ports 2,5 and change DATA/PORT_EN every cycle -> WDATA stays 0xABC and WVALID stays 6'h24 until released.
- Assert RST asynchronously between clock edges while PEND=6'h24 -> WVALID=0 and BUSY=0 immediately; READY=1; next word accepted on the first edge after release.

Source files
------------

// File: rtl/net_bus_tx_fanout.sv
// NetBus transmit fan-out: one registered word presented to PORTS links; retired once every target port has taken it.
// Latency: 1 cycle from accept to WVALID; empty-target words pulse DROP the cycle after acceptance.
// Backpressure: READY falls while any pending port stays un-handshaken this cycle; rises combinationally on the final WREADY.
module net_bus_tx_fanout #(
  parameter int DATA_WIDTH = 4,
  parameter int PORTS      = 6,
  parameter int MODE       = 0,
  parameter int DEST_W     = 4,
  localparam int W         = DATA_WIDTH * 9 + 14
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [W-1:0]       DATA,
  input  logic               VALID,
  output logic               READY,
  input  logic [PORTS-1:0]   PORT_EN,
  input  logic [DEST_W-1:0]  DEST,
  output logic [PORTS-1:0]   WCLK,
  output logic [PORTS*W-1:0] WDATA,
  output logic [PORTS-1:0]   WVALID,
  input  logic [PORTS-1:0]   WREADY,
  output logic               DROP,
  output logic               BUSY
);

  // Held word, per-port pending mask and the registered drop pulse.
  logic [W-1:0]     wreg;
  logic [PORTS-1:0] pend;
  logic             drop_q;

  // Per-cycle delivery and retirement terms.
  logic [PORTS-1:0] tgt;
  logic [PORTS-1:0] hs;
  logic             last;
  logic             busy;
  logic             accept;

  // Target mask for the incoming word: the broadcast mask, or a one-hot of DEST
  // (an out-of-range DEST matches no port and yields an empty mask).
  always_comb begin
    tgt = '0;
    if (MODE == 0) begin
      tgt = PORT_EN;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        tgt[i] = (DEST == DEST_W'(i));
      end
    end
  end

  assign hs     = pend & WREADY;
  assign last   = ((pend & ~hs) == '0);
  assign busy   = |pend;
  assign accept = VALID & READY;

  // Word register and pending mask; a new accept overrides the final clears of
  // the retiring word so back-to-back words need no gap cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wreg   <= '0;
      pend   <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= accept && (tgt == '0);
      if (accept) begin
        wreg <= DATA;
        pend <= tgt;
      end else begin
        pend <= pend & ~WREADY;
      end
    end
  end

  assign READY  = ~busy | last;
  assign BUSY   = busy;
  assign DROP   = drop_q;
  assign WVALID = pend;
  assign WDATA  = {PORTS{wreg}};
  assign WCLK   = {PORTS{CLK}};

endmodule
